// File: rtl/i2s_mic_capture.sv
// i2s_mic_capture: drives an INMP441-style I2S MEMS microphone (SCK/WS),
// deserialises one channel of SD and presents a held signed 24-bit sample
// with a one-clk strobe per audio frame.
// Optional DC-removal stage is compiled in with `define I2S_MIC_DC_REMOVE_EN.
module i2s_mic_capture #(
    parameter int unsigned SCK_HALF_PERIOD = 8,
    parameter int unsigned CHANNEL         = 0,
    parameter int unsigned DC_SHIFT        = 10
) (
    input  logic        clk,
    input  logic        rst,
    output logic        sck_o,
    output logic        ws_o,
    input  logic        sd_i,
    output logic [23:0] mic_o,
    output logic        mic_valid_o
);

    localparam int unsigned SAMPLE_W = 24;
    localparam int unsigned SLOT_W   = 6;
    localparam int unsigned DIV_W    = (SCK_HALF_PERIOD > 1) ? $clog2(SCK_HALF_PERIOD) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_HALF_PERIOD - 1);
    localparam logic CH_SEL = 1'(CHANNEL);
    localparam logic [4:0] FIRST_BIT_SLOT = 5'd1;
    localparam logic [4:0] LAST_BIT_SLOT  = 5'd24;

    // Reject parameter values the divider and filter cannot support
    if (SCK_HALF_PERIOD < 2) begin : g_bad_half_period
        $error("i2s_mic_capture: SCK_HALF_PERIOD must be at least 2");
    end
    if (DC_SHIFT == 0 || DC_SHIFT > 32) begin : g_bad_dc_shift
        $error("i2s_mic_capture: DC_SHIFT must be in 1..32");
    end

    logic [DIV_W-1:0]    div_q,   div_d;
    logic                sck_q,   sck_d;
    logic [SLOT_W-1:0]   slot_q,  slot_d;
    logic                ws_q,    ws_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic                done_q,  done_d;
    logic [SAMPLE_W-1:0] mic_q,   mic_d;
    logic                valid_q, valid_d;

    logic                div_tc;
    logic                rise_evt;
    logic                fall_evt;
    logic [4:0]          slot_lo;
    logic                in_window;
    logic [SAMPLE_W-1:0] sample_out;

    // Event decode: SCK toggles at the divider terminal count
    always_comb begin
        div_tc    = (div_q == DIV_LAST);
        rise_evt  = div_tc & ~sck_q;
        fall_evt  = div_tc &  sck_q;
        slot_lo   = slot_q[4:0];
        in_window = (ws_q == CH_SEL)
                  && (slot_lo >= FIRST_BIT_SLOT)
                  && (slot_lo <= LAST_BIT_SLOT);
    end

`ifdef I2S_MIC_DC_REMOVE_EN
    localparam int unsigned ACC_W = SAMPLE_W + DC_SHIFT;
    localparam logic [SAMPLE_W-1:0] SAT_POS = 24'h7F_FFFF;
    localparam logic [SAMPLE_W-1:0] SAT_NEG = 24'h80_0000;

    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [SAMPLE_W-1:0] avg;
    logic signed [SAMPLE_W-1:0] x_s;
    logic signed [SAMPLE_W:0]   diff;

    // DC-blocked sample: subtract running average, saturate to 24 bits
    always_comb begin
        x_s  = $signed(shift_q);
        avg  = SAMPLE_W'(acc_q >>> DC_SHIFT);
        diff = (SAMPLE_W+1)'(x_s) - (SAMPLE_W+1)'(avg);
        if (diff[SAMPLE_W] != diff[SAMPLE_W-1]) begin
            sample_out = diff[SAMPLE_W] ? SAT_NEG : SAT_POS;
        end else begin
            sample_out = diff[SAMPLE_W-1:0];
        end
        acc_d = acc_q;
        if (done_q) begin
            acc_d = acc_q + ACC_W'(x_s) - ACC_W'(avg);
        end
    end

    // Leaky-average accumulator, one update per completed sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    // Raw sample passes straight through
    always_comb begin
        sample_out = shift_q;
    end
`endif

    // Next-state logic for divider, slot counter, shifter and output stage
    always_comb begin
        div_d   = div_tc ? '0 : div_q + DIV_W'(1);
        sck_d   = sck_q ^ div_tc;
        slot_d  = fall_evt ? slot_q + SLOT_W'(1) : slot_q;
        ws_d    = slot_d[SLOT_W-1];
        shift_d = shift_q;
        done_d  = 1'b0;
        mic_d   = mic_q;
        valid_d = 1'b0;

        if (rise_evt && in_window) begin
            shift_d = {shift_q[SAMPLE_W-2:0], sd_i};
            done_d  = (slot_lo == LAST_BIT_SLOT);
        end

        if (done_q) begin
            mic_d   = sample_out;
            valid_d = 1'b1;
        end
    end

    // State registers; reset discards any partial frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            sck_q   <= 1'b0;
            slot_q  <= '0;
            ws_q    <= 1'b0;
            shift_q <= '0;
            done_q  <= 1'b0;
            mic_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            sck_q   <= sck_d;
            slot_q  <= slot_d;
            ws_q    <= ws_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            mic_q   <= mic_d;
            valid_q <= valid_d;
        end
    end

    assign sck_o       = sck_q;
    assign ws_o        = ws_q;
    assign mic_o       = mic_q;
    assign mic_valid_o = valid_q;

endmodule

// File: tb/tb_i2s_mic_capture.sv
// Directed bench for i2s_mic_capture: a behavioural I2S microphone drives SD
// from the DUT's SCK/WS, and each scenario checks strobe timing and sample
// values against hand-computed constants. Two instances: left and right.
module tb_i2s_mic_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sd  = 1'b1;
    logic        sck0, ws0, v0;
    logic        sck1, ws1, v1;
    logic [23:0] mic0, mic1;

    logic [23:0] left_word  = 24'h0;
    logic [23:0] right_word = 24'h0;
    logic        fill       = 1'b1;

    int checks   = 0;
    int failures = 0;
    int dbl      = 0;

    int   idx      = 0;
    logic prev_sck = 1'b0;
    logic prev_ws  = 1'b0;
    logic prev_v0  = 1'b0;
    logic prev_v1  = 1'b0;

    always #5 clk = ~clk;

    i2s_mic_capture #(.SCK_HALF_PERIOD(8), .CHANNEL(0), .DC_SHIFT(10)) dut0 (
        .clk(clk), .rst(rst), .sck_o(sck0), .ws_o(ws0), .sd_i(sd),
        .mic_o(mic0), .mic_valid_o(v0)
    );

    i2s_mic_capture #(.SCK_HALF_PERIOD(8), .CHANNEL(1), .DC_SHIFT(10)) dut1 (
        .clk(clk), .rst(rst), .sck_o(sck1), .ws_o(ws1), .sd_i(sd),
        .mic_o(mic1), .mic_valid_o(v1)
    );

    function automatic logic bit_for(input int i, input logic w);
        logic [23:0] word;
        word = w ? right_word : left_word;
        if (i >= 1 && i <= 24) return word[24-i];
        return fill;
    endfunction

    // Microphone model: new bit after each SCK fall, slot 0 restarts on WS edge
    always @(negedge clk) begin
        if (rst) begin
            idx      = 0;
            prev_sck = 1'b0;
            prev_ws  = 1'b0;
        end else begin
            if (prev_sck && !sck0) begin
                if (ws0 != prev_ws) idx = 0;
                else                idx = idx + 1;
            end
            prev_sck = sck0;
            prev_ws  = ws0;
        end
        sd = bit_for(idx, ws0);
    end

    // Strobe monitor: valid must never be high in two consecutive cycles
    always begin
        @(posedge clk);
        #1;
        if ((v0 && prev_v0) || (v1 && prev_v1)) dbl++;
        prev_v0 = v0;
        prev_v1 = v1;
    end

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
    endtask

    // Collects strobe times/values and off-strobe mic changes over ncyc edges
    task automatic watch(input int ncyc, input bit sel,
                         output int t1, output int t2, output int cnt,
                         output logic [23:0] m1, output logic [23:0] m2,
                         output int stray);
        logic [23:0] pm, m;
        logic        v;
        t1 = -1; t2 = -1; cnt = 0; m1 = '0; m2 = '0; stray = 0;
        pm = sel ? mic1 : mic0;
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk);
            #1;
            m = sel ? mic1 : mic0;
            v = sel ? v1 : v0;
            if (v) begin
                cnt++;
                if (t1 < 0) begin t1 = n; m1 = m; end
                else if (t2 < 0) begin t2 = n; m2 = m; end
            end else if (m !== pm) begin
                stray++;
            end
            pm = m;
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (sck0 !== 1'b0) begin failures++; $display("FAIL reset_sck: got %b expected 0", sck0); end
        checks++; if (ws0 !== 1'b0) begin failures++; $display("FAIL reset_ws: got %b expected 0", ws0); end
        checks++; if (mic0 !== 24'h0) begin failures++; $display("FAIL reset_mic: got %h expected 000000", mic0); end
        checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", v0); end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (sck0 !== 1'b0 || sck1 !== 1'b0) begin failures++; $display("FAIL reset_hold_sck: got %b/%b expected 0/0", sck0, sck1); end
        checks++; if (mic1 !== 24'h0 || v1 !== 1'b0) begin failures++; $display("FAIL reset_hold_right: got mic %h valid %b expected 000000/0", mic1, v1); end
        #2 rst = 1'b0;
    endtask

    task automatic test_clock_gen();
        int   first_rise, last_rise, last_ws_rise, ws_period;
        int   bad_period, bad_duty, bad_ws_edge;
        logic ps, pw;
        first_rise = -1; last_rise = -1; last_ws_rise = -1; ws_period = -1;
        bad_period = 0; bad_duty = 0; bad_ws_edge = 0;
        ps = 1'b0; pw = 1'b0;
        do_reset();
        for (int n = 1; n <= 2200; n++) begin
            @(posedge clk);
            #1;
            if (sck0 && !ps) begin
                if (first_rise < 0) first_rise = n;
                if (last_rise >= 0 && n - last_rise != 16) bad_period++;
                last_rise = n;
            end
            if (!sck0 && ps) begin
                if (last_rise < 0 || n - last_rise != 8) bad_duty++;
            end
            if (ws0 != pw) begin
                if (!(ps && !sck0)) bad_ws_edge++;
                if (ws0) begin
                    if (last_ws_rise >= 0) ws_period = n - last_ws_rise;
                    last_ws_rise = n;
                end
            end
            ps = sck0;
            pw = ws0;
        end
        checks++; if (first_rise !== 8) begin failures++; $display("FAIL clk_first_rise: got %0d expected 8", first_rise); end
        checks++; if (bad_period !== 0) begin failures++; $display("FAIL clk_sck_period: got %0d bad periods expected 0", bad_period); end
        checks++; if (bad_duty !== 0) begin failures++; $display("FAIL clk_sck_duty: got %0d bad high times expected 0", bad_duty); end
        checks++; if (bad_ws_edge !== 0) begin failures++; $display("FAIL clk_ws_on_fall: got %0d misplaced ws edges expected 0", bad_ws_edge); end
        checks++; if (ws_period !== 1024) begin failures++; $display("FAIL clk_ws_period: got %0d expected 1024", ws_period); end
    endtask

    task automatic test_left_capture();
        int t1, t2, cnt, stray;
        logic [23:0] m1, m2;
        left_word = 24'h800001; right_word = 24'h3C3C3C; fill = 1'b1;
        do_reset();
        watch(2500, 1'b0, t1, t2, cnt, m1, m2, stray);
        checks++; if (t1 !== 393) begin failures++; $display("FAIL left_first_strobe: got %0d expected 393", t1); end
        checks++; if (m1 !== 24'h800001) begin failures++; $display("FAIL left_value: got %h expected 800001", m1); end
        checks++; if (t2 !== 1417) begin failures++; $display("FAIL left_second_strobe: got %0d expected 1417", t2); end
        checks++; if (m2 !== 24'h800001) begin failures++; $display("FAIL left_value2: got %h expected 800001", m2); end
        checks++; if (cnt !== 3) begin failures++; $display("FAIL left_strobe_count: got %0d expected 3", cnt); end
        checks++; if (stray !== 0) begin failures++; $display("FAIL left_stray_change: got %0d expected 0", stray); end
    endtask

    task automatic test_right_select();
        int t1, t2, cnt, stray;
        logic [23:0] m1, m2;
        left_word = 24'h123456; right_word = 24'hABCDEF; fill = 1'b1;
        do_reset();
        watch(2000, 1'b1, t1, t2, cnt, m1, m2, stray);
        checks++; if (t1 !== 905) begin failures++; $display("FAIL right_first_strobe: got %0d expected 905", t1); end
        checks++; if (m1 !== 24'hABCDEF) begin failures++; $display("FAIL right_value: got %h expected abcdef", m1); end
        checks++; if (t2 !== 1929) begin failures++; $display("FAIL right_second_strobe: got %0d expected 1929", t2); end
        checks++; if (cnt !== 2) begin failures++; $display("FAIL right_strobe_count: got %0d expected 2", cnt); end
        checks++; if (stray !== 0) begin failures++; $display("FAIL right_stray_change: got %0d expected 0", stray); end
        checks++; if (mic0 !== 24'h123456) begin failures++; $display("FAIL right_left_instance: got %h expected 123456", mic0); end
    endtask

    task automatic test_reset_mid_frame();
        int t1, t2, cnt, stray;
        logic [23:0] m1, m2;
        left_word = 24'h00FFFF; right_word = 24'h0; fill = 1'b1;
        do_reset();
        watch(200, 1'b0, t1, t2, cnt, m1, m2, stray);
        checks++; if (cnt !== 0 || mic0 !== 24'h0) begin failures++; $display("FAIL mid_before_reset: got %0d strobes mic %h expected 0/000000", cnt, mic0); end
        left_word = 24'h7FFFFF;
        do_reset();
        watch(1500, 1'b0, t1, t2, cnt, m1, m2, stray);
        checks++; if (t1 !== 393) begin failures++; $display("FAIL mid_first_strobe: got %0d expected 393", t1); end
        checks++; if (m1 !== 24'h7FFFFF) begin failures++; $display("FAIL mid_value: got %h expected 7fffff", m1); end
        checks++; if (cnt !== 2) begin failures++; $display("FAIL mid_strobe_count: got %0d expected 2", cnt); end
        checks++; if (stray !== 0) begin failures++; $display("FAIL mid_stray_change: got %0d expected 0", stray); end
    endtask

    task automatic test_boundary_bits();
        int t1, t2, cnt, stray;
        logic [23:0] m1, m2;
        left_word = 24'hFFFFFF; right_word = 24'h000000; fill = 1'b0;
        do_reset();
        watch(400, 1'b0, t1, t2, cnt, m1, m2, stray);
        checks++; if (m1 !== 24'hFFFFFF || t1 !== 393) begin failures++; $display("FAIL bound_ones: got %h at %0d expected ffffff at 393", m1, t1); end
        left_word = 24'h000000; right_word = 24'hFFFFFF; fill = 1'b1;
        do_reset();
        watch(400, 1'b0, t1, t2, cnt, m1, m2, stray);
        checks++; if (m1 !== 24'h000000 || t1 !== 393) begin failures++; $display("FAIL bound_zeros: got %h at %0d expected 000000 at 393", m1, t1); end
    endtask

    task automatic test_back_to_back();
        int t1, t2, cnt, stray;
        logic [23:0] m1, m2;
        left_word = 24'hA5A5A5; right_word = 24'h0; fill = 1'b1;
        do_reset();
        watch(400, 1'b0, t1, t2, cnt, m1, m2, stray);
        checks++; if (m1 !== 24'hA5A5A5) begin failures++; $display("FAIL b2b_first: got %h expected a5a5a5", m1); end
        left_word = 24'h5A5A5B;
        watch(1100, 1'b0, t1, t2, cnt, m1, m2, stray);
        checks++; if (t1 !== 1017) begin failures++; $display("FAIL b2b_spacing: got %0d expected 1017", t1); end
        checks++; if (m1 !== 24'h5A5A5B) begin failures++; $display("FAIL b2b_second: got %h expected 5a5a5b", m1); end
        checks++; if (stray !== 0) begin failures++; $display("FAIL b2b_stray_change: got %0d expected 0", stray); end
    endtask

    initial begin
        test_reset();
        test_clock_gen();
        test_left_capture();
        test_right_select();
        test_reset_mid_frame();
        test_boundary_bits();
        test_back_to_back();
        checks++; if (dbl !== 0) begin failures++; $display("FAIL valid_consecutive: got %0d double strobes expected 0", dbl); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_mic_capture.md
Name: i2s_mic_capture

Overview:
- Upstream stage of the oscilloscope and sound labs: drives an INMP441-style I2S MEMS microphone and deserialises one channel into the signed 24-bit mic bus consumed by lab_top.
- Generates SCK and WS from clk, samples SD, and presents a held 24-bit sample plus a one-cycle strobe per audio frame.

Parameters:
- sck_half_period, 8, clk cycles per SCK half-period (≥2); 50 MHz gives SCK 3.125 MHz, frame rate 48.83 kHz.
- channel, 0, captured WS half: 0 = left (WS low), 1 = right (WS high).
- dc_shift, 10, DC-removal filter time constant, 2^dc_shift samples (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- sck  out  1  I2S bit clock to microphone
- ws  out  1  I2S word select to microphone
- sd  in  1  I2S serial data from microphone
- mic  out  24  last captured sample, two's complement, held between strobes
- mic_valid  out  1  one-clk strobe when mic updates

Behaviour:
- Reset values: sck=0, ws=0, mic=0, mic_valid=0. Divider, slot counter, shift register and filter state are all 0.
- Divider:
  - div_cnt counts 0..sck_half_period-1 and wraps.
  - At the terminal count sck toggles.
  - A toggle from 0 to 1 is a rise event; a toggle from 1 to 0 is a fall event.
  - All events are single-clk internal pulses.
- Slot counter:
  - slot is 6 bits, 0..63, incremented on each fall event and wraps 63->0.
  - ws is registered as slot[5]; it changes only on fall events, so WS transitions coincide with SCK falling edges.
- Capture window: on a rise event with ws==channel and slot[4:0] in 1..24, shift <= {shift[22:0], sd}. This is MSB first, with the MSB one SCK after the WS edge, per I2S.
- Ignored input: slots 0 and 25..31 of the captured half, and the entire other half, are ignored (SD is tri-state there).
- Output update: on the rise event of slot[4:0]==24 in the captured half, the shift completes. On the next clk edge mic <= the completed shift value and mic_valid=1 for exactly one cycle.
- Timing:
  - Strobe period is 64*2*sck_half_period clk cycles (1024 at default).
  - First strobe after reset release follows 25 rise events into the captured half, plus 1 clk.
- No partial samples:
  - mic changes only on a strobe.
  - Reset mid-frame discards the partial shift; capture restarts from slot 0 and ws=0.
- Lab_top contract: mic_valid is never asserted in two consecutive cycles, and mic is stable between strobes.
- Width rules: no truncation or extension in the default build; mic equals the 24 received bits exactly.

Optional Feature:
- Macro: I2S_MIC_DC_REMOVE_EN
- When defined:
  - mic is the DC-blocked sample y = x - avg.
  - avg is a 24+dc_shift bit accumulator: acc <= acc + x - (acc >>> dc_shift), and avg = acc >>> dc_shift.
  - The accumulator updates once per strobe and resets to 0.
  - y saturates to the range -8388608..8388607.
  - mic_valid timing is unchanged; y is computed in the same registered stage.
- When undefined: no accumulator logic is present, and mic is the raw sample.

Test Plan:
- Clock gen: release reset and watch sck/ws -> sck period 16 clk, 50% duty; ws period 1024 clk; ws edges only on sck falling edges.
- Left capture: mic model drives 24'h800001 MSB-first in left slots 1..24 and 1 elsewhere; channel=0 -> mic=24'h800001 with a one-cycle mic_valid every 1024 clk; no strobe in the right half.
- Right select: channel=1 with left data 24'h123456 and right data 24'hABCDEF -> mic=24'hABCDEF only.
- Reset mid-frame: assert rst at left slot 12 with data 24'h00FFFF, release, then send 24'h7FFFFF -> mic=0 until the first full frame, then 24'h7FFFFF; never a mixed value.
- Boundary bits: data 24'hFFFFFF with sd=0 in slots 0 and 25..31 -> mic=24'hFFFFFF (-1); data 24'h000000 with sd=1 in the ignored slots -> mic=0.
- DC removal (macro defined, dc_shift=4): constant input 24'd1000 for 200 frames -> mic decays monotonically from 1000 to |mic|<16; sign flip to -1000 gives a negative step of about -2000, saturation never exceeded.
